// File: rtl/main.sv
// Board top for the i4001 demo: MCLK-stepped 16x16 switch capture shown on a row-scanned DMD and 4-digit 7-segment display.
// Optional MCLK_DEBOUNCE_EN adds a DEBOUNCE-cycle level filter on the synchronized MCLK.
module main #(
  parameter int SCAN_DIV = 1024,
  parameter int ROW_DIV  = 256,
  parameter int DEBOUNCE = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] in,
  input  logic        MCLK,
  input  logic        SWITCH,
  output logic [7:0]  seg_pattern,
  output logic [3:0]  seg_digit,
  output logic        DMD_CLR,
  output logic [3:0]  dmd_seg,
  output logic [15:0] dmd_column,
  output logic        DMD_CLK
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;

  if (SCAN_DIV < 2 || ROW_DIV < 4 || DEBOUNCE < 1) begin : g_param_check
    $error("main: SCAN_DIV must be >=2, ROW_DIV >=4, DEBOUNCE >=1");
  end

  logic        ms1, ms2, lvl, lvl_d, step;
  logic [15:0] fbuf [16];
  logic [3:0]  wp;
  logic [15:0] cnt, last;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ms1   <= 1'b0;
      ms2   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      ms1   <= MCLK;
      ms2   <= ms1;
      lvl_d <= lvl;
    end
  end

`ifdef MCLK_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  logic [DB_W-1:0] db_cnt;
  logic            filt;

  // filt only follows ms2 after DEBOUNCE consecutive cycles of disagreement
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (ms2 != filt) begin
      if (db_cnt == DB_LAST) begin
        filt   <= ms2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = ms2;
`endif

  assign step = lvl & ~lvl_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) fbuf[i] <= '0;
      wp   <= '0;
      cnt  <= '0;
      last <= '0;
    end else if (step) begin
      fbuf[wp] <= in;
      last     <= in;
      wp       <= wp + 4'd1;
      cnt      <= cnt + 16'd1;
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] p;
    case (v)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [1:0]    dig;
  logic [15:0]   value;
  logic [3:0]    nib;

  assign value = SWITCH ? cnt : last;
  assign nib   = value[4*dig +: 4];

  // Outputs refresh every cycle from the current digit, so value changes appear without waiting a full scan
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt    <= '0;
      dig         <= '0;
      seg_pattern <= 8'hFF;
      seg_digit   <= 4'b1111;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig      <= dig + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg_digit   <= ~(4'b0001 << dig);
      seg_pattern <= hex7(nib);
    end
  end

  logic [RW-1:0] row_ph;
  logic [3:0]    row;

  // Column data is latched once at the start of each row period and held until the next one
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      row_ph     <= '0;
      row        <= '0;
      DMD_CLR    <= 1'b1;
      DMD_CLK    <= 1'b0;
      dmd_seg    <= '0;
      dmd_column <= '0;
    end else begin
      if (row_ph == RW'(ROW_DIV - 1)) begin
        row_ph <= '0;
        row    <= row + 4'd1;
      end else begin
        row_ph <= row_ph + 1'b1;
      end
      if (row_ph == '0) begin
        DMD_CLR    <= 1'b1;
        dmd_seg    <= row;
        dmd_column <= fbuf[row];
      end else if (row_ph >= RW'(2)) begin
        DMD_CLR <= 1'b0;
      end
      DMD_CLK <= (row_ph == RW'(1));
    end
  end

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for main: stimulus pushes expected display/row contents, negedge monitors pop and compare.
module tb_main;
  localparam int S = 4;
  localparam int R = 8;
`ifdef MCLK_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] din = '0;
  logic        mclk = 1'b0;
  logic        sw = 1'b0;
  logic [7:0]  seg_pattern;
  logic [3:0]  seg_digit;
  logic        DMD_CLR, DMD_CLK;
  logic [3:0]  dmd_seg;
  logic [15:0] dmd_column;

  main #(.SCAN_DIV(S), .ROW_DIV(R), .DEBOUNCE(16)) dut (
    .CLK(CLK), .RESET(RESET), .in(din), .MCLK(mclk), .SWITCH(sw),
    .seg_pattern(seg_pattern), .seg_digit(seg_digit), .DMD_CLR(DMD_CLR),
    .dmd_seg(dmd_seg), .dmd_column(dmd_column), .DMD_CLK(DMD_CLK)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [3:0] mask; logic [7:0] pat; } seg_e;
  typedef struct { logic [3:0] row; logic [15:0] col; } dmd_e;
  seg_e sq[$];
  dmd_e dq[$];

  logic [7:0]  enc [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [15:0] mbuf [16];
  int          mwp, mcnt;
  logic [15:0] mlast;
  int          cyc;
  int          checks = 0, passes = 0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  // Continuous timing checks plus queued content checks
  always @(negedge CLK) begin
    if (RESET) begin
      chk("rst seg_pattern", {24'd0, seg_pattern}, 32'hFF);
      chk("rst seg_digit", {28'd0, seg_digit}, 32'hF);
      chk("rst dmd", {15'd0, DMD_CLR, DMD_CLK, dmd_seg, dmd_column}, {15'd0, 1'b1, 1'b0, 4'd0, 16'd0});
    end else begin
      automatic int n = cyc;
      automatic logic [3:0] ed = (n == 0) ? 4'hF : ~(4'b0001 << (((n - 1) / S) % 4));
      chk("seg_digit scan", {28'd0, seg_digit}, {28'd0, ed});
      chk("DMD_CLK timing", {31'd0, DMD_CLK}, {31'd0, (n >= 2 && (n - 2) % R == 0)});
      chk("DMD_CLR timing", {31'd0, DMD_CLR}, {31'd0, (n == 0 || (n - 1) % R < 2)});
      if (n >= 1) chk("dmd_seg row", {28'd0, dmd_seg}, 32'(((n - 1) / R) % 16));
      if (n >= 1 && (n - 1) % S == S / 2 && sq.size() > 0) begin
        automatic seg_e e = sq.pop_front();
        chk("seg digit mask", {28'd0, seg_digit}, {28'd0, e.mask});
        chk("seg_pattern", {24'd0, seg_pattern}, {24'd0, e.pat});
      end
      if (DMD_CLK && dq.size() > 0) begin
        automatic dmd_e e = dq.pop_front();
        chk("dmd row addr", {28'd0, dmd_seg}, {28'd0, e.row});
        chk("dmd_column", {16'd0, dmd_column}, {16'd0, e.col});
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mbuf[i] = '0;
    mwp = 0; mcnt = 0; mlast = '0;
    sq.delete(); dq.delete();
  endtask

  task automatic do_step(input logic [15:0] d);
    @(negedge CLK);
    din = d; mclk = 1'b1;
    repeat (LAT + 1) @(negedge CLK);
    mbuf[mwp] = d; mwp = (mwp + 1) % 16; mcnt = (mcnt + 1) % 65536; mlast = d;
    mclk = 1'b0;
    repeat (LAT + 1) @(negedge CLK);
  endtask

  // Queue one full digit scan and one full frame of expected output, then wait for the monitor to drain them
  task automatic check_all();
    int n, k;
    logic [15:0] v;
    @(negedge CLK); #1;
    n = cyc;
    v = sw ? 16'(mcnt) : mlast;
    k = (n == 0) ? 0 : (((n - 1) % S < S / 2) ? (n - 1) / S : (n - 1) / S + 1);
    for (int j = 0; j < 4; j++) begin
      automatic int d = (k + j) % 4;
      automatic logic [15:0] sh = v >> (4 * d);
      sq.push_back('{mask: ~(4'b0001 << d), pat: enc[sh[3:0]]});
    end
    k = (n < 2) ? 0 : (n - 2) / R + 1;
    for (int j = 0; j < 16; j++) begin
      automatic int r = (k + j) % 16;
      dq.push_back('{row: 4'(r), col: mbuf[r]});
    end
    for (int i = 0; i < 20 * R + 8 * S + 20 && (sq.size() > 0 || dq.size() > 0); i++)
      @(negedge CLK);
    checks++;
    if (sq.size() == 0 && dq.size() == 0) passes++;
    else $display("FAIL scoreboard drain: %0d seg and %0d dmd entries left, expected 0", sq.size(), dq.size());
    sq.delete(); dq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    RESET = 1'b1;
    #1;
    chk("async seg", {20'd0, seg_pattern, seg_digit}, {20'd0, 8'hFF, 4'hF});
    chk("async dmd", {15'd0, DMD_CLR, DMD_CLK, dmd_seg, dmd_column}, {15'd0, 1'b1, 1'b0, 4'd0, 16'd0});
    repeat (3) @(negedge CLK);
    model_clear();
    RESET = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    sw = 1'b0;
    check_all();
    do_step(16'h0001);
    check_all();
    sw = 1'b1; check_all();
    do_step(16'h0002);
    check_all();
    sw = 1'b0; check_all();

    do_reset();
    for (int i = 0; i < 17; i++) do_step(16'hABCD);
    sw = 1'b0; check_all();
    sw = 1'b1; check_all();

`ifdef MCLK_DEBOUNCE_EN
    @(negedge CLK); din = 16'h5555; mclk = 1'b1;
    repeat (5) @(negedge CLK); mclk = 1'b0;
    repeat (30) @(negedge CLK);
    check_all();
`endif

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) do_step(16'($urandom));
      if ($urandom_range(0, 3) == 0) do_step(16'($urandom));
      sw = 1'($urandom_range(0, 1));
      if (i % 3 == 2) check_all();
    end

    do_step(16'h1234);
    do_reset();
    sw = 1'b1; check_all();
    sw = 1'b0; check_all();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
